// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 3x3 membrane keypad, debounces whole-frame results
// and presents a committed key code, a held level and a one-cycle press strobe.

// Two-flop synchronizer for one active-low column sense line.
module colSync (
  input  logic hwclk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  // Idle level of a pulled-up column is 1, so reset to inactive.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 1200,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       hwclk,
  input  logic       reset,
  output logic       keypad_r1,
  output logic       keypad_r2,
  output logic       keypad_r3,
  input  logic       keypad_c1,
  input  logic       keypad_c2,
  input  logic       keypad_c3,
  output logic [3:0] button,
  output logic       bstate,
  output logic       press
);
  localparam int DW = $clog2(SETTLE_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic {IDLE, HELD} state_t;

  logic [2:0]    colRaw, colSyncd, colAct;
  logic [DW-1:0] dwellCnt;
  logic [1:0]    rowIdx;
  logic          lastDwell, frameEnd;

  // Frame accumulator: something seen, something illegal seen, last code seen.
  logic          accHit, accBad;
  logic [3:0]    accCode;
  logic          sampHit, sampMulti;
  logic [1:0]    colNum;
  logic [3:0]    sampCode, nextCode, frameRes;
  logic          nextHit, nextBad;

  logic [3:0]    candidate;
  logic [CW-1:0] dbCnt;
  logic          match, commit;

  state_t        state, stateNext;
  logic [3:0]    buttonNext;
  logic          bstateNext, pressNext;

  assign colRaw = {keypad_c3, keypad_c2, keypad_c1};

  for (genvar i = 0; i < 3; i++) begin : gSync
    colSync uSync (.hwclk(hwclk), .reset(reset), .d(colRaw[i]), .q(colSyncd[i]));
  end

  assign colAct    = ~colSyncd;
  assign lastDwell = (dwellCnt == DW'(SETTLE_CYCLES - 1));
  assign frameEnd  = lastDwell && (rowIdx == 2'd2);

  // Row drive: all rows released during reset, otherwise only the scanned row low.
  always_comb begin
    {keypad_r3, keypad_r2, keypad_r1} = 3'b111;
    if (!reset) begin
      case (rowIdx)
        2'd0:    keypad_r1 = 1'b0;
        2'd1:    keypad_r2 = 1'b0;
        default: keypad_r3 = 1'b0;
      endcase
    end
  end

  // Fold the current row's sample into the frame; multi-hit or multi-row is illegal.
  always_comb begin
    sampHit   = (colAct != 3'b000);
    sampMulti = ((colAct & (colAct - 3'd1)) != 3'b000);
    case (colAct)
      3'b010:  colNum = 2'd2;
      3'b100:  colNum = 2'd3;
      default: colNum = 2'd1;
    endcase
    sampCode = 4'(rowIdx) * 4'd3 + {2'b00, colNum};
    nextHit  = accHit | sampHit;
    nextBad  = accBad | sampMulti | (sampHit & accHit);
    nextCode = sampHit ? sampCode : accCode;
    frameRes = (nextHit && !nextBad) ? nextCode : 4'd0;
  end

  // Dwell counter, row sequencer and per-row sampling into the accumulator.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      dwellCnt <= '0;
      rowIdx   <= 2'd0;
      accHit   <= 1'b0;
      accBad   <= 1'b0;
      accCode  <= 4'd0;
    end else if (lastDwell) begin
      dwellCnt <= '0;
      rowIdx   <= (rowIdx == 2'd2) ? 2'd0 : rowIdx + 2'd1;
      if (frameEnd) begin
        accHit  <= 1'b0;
        accBad  <= 1'b0;
        accCode <= 4'd0;
      end else begin
        accHit  <= nextHit;
        accBad  <= nextBad;
        accCode <= nextCode;
      end
    end else begin
      dwellCnt <= dwellCnt + 1'b1;
    end
  end

  // Commit fires only on the frame where the run of equal results first hits the target.
  assign match  = (frameRes == candidate);
  assign commit = frameEnd &&
                  ((DEBOUNCE_FRAMES == 1) || (match && dbCnt == CW'(DEBOUNCE_FRAMES - 1)));

  // Per-frame debounce: count consecutive equal results, saturating.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      candidate <= 4'd0;
      dbCnt     <= '0;
    end else if (frameEnd) begin
      if (match) begin
        if (dbCnt != CW'(DEBOUNCE_FRAMES)) dbCnt <= dbCnt + 1'b1;
      end else begin
        candidate <= frameRes;
        dbCnt     <= CW'(1);
      end
    end
  end

  // Press/release FSM; a different key committed while held is ignored.
  always_comb begin
    stateNext  = state;
    buttonNext = button;
    bstateNext = bstate;
    pressNext  = 1'b0;
    case (state)
      IDLE: if (commit && frameRes != 4'd0) begin
        stateNext  = HELD;
        buttonNext = frameRes;
        bstateNext = 1'b1;
        pressNext  = 1'b1;
      end
      HELD: if (commit && frameRes == 4'd0) begin
        stateNext  = IDLE;
        bstateNext = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state  <= IDLE;
      button <= 4'd0;
      bstate <= 1'b0;
      press  <= 1'b0;
    end else begin
      state  <= stateNext;
      button <= buttonNext;
      bstate <= bstateNext;
      press  <= pressNext;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random key patterns,
// checked every cycle against a frame-level reference model.
module tb_keypad_scanner;
  localparam int S     = 4;
  localparam int D     = 3;
  localparam int FRAME = 3 * S;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic       r1, r2, r3;
  logic [2:0] colN;
  logic [3:0] button;
  logic       bstate, press;
  logic [2:0] rowsOut;
  logic [8:0] keys = 9'd0;

  int nCmp = 0, nErr = 0;
  int hist[$];
  int expButton = 0, expBstate = 0, pendPress = 0;

  keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_FRAMES(D)) dut (
    .hwclk(hwclk), .reset(reset),
    .keypad_r1(r1), .keypad_r2(r2), .keypad_r3(r3),
    .keypad_c1(colN[0]), .keypad_c2(colN[1]), .keypad_c3(colN[2]),
    .button(button), .bstate(bstate), .press(press)
  );

  always #5 hwclk = ~hwclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Keypad: a held key pulls its column low while its row is driven low.
  assign rowsOut = {r3, r2, r1};
  always_comb begin
    colN = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++)
        if (rowsOut[r] == 1'b0 && keys[r*3+j]) colN[j] = 1'b0;
  end

  task automatic check(input string tag, input int got, input int exp);
    nCmp++;
    if (got != exp) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // A frame names a key only when exactly one key is held.
  function automatic int frameResult(input logic [8:0] k);
    if ($countones(k) != 1) return 0;
    for (int i = 0; i < 9; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  // Reference: commit when the last D results agree and the run has just reached D.
  task automatic modelFrame();
    int r, f;
    bit commit;
    r = frameResult(keys);
    hist.push_back(r);
    f = hist.size() - 1;
    commit = 1'b0;
    if (D == 1) commit = 1'b1;
    else if (f >= D - 1) begin
      commit = 1'b1;
      for (int i = 1; i < D; i++) if (hist[f-i] != r) commit = 1'b0;
      if (f >= D && hist[f-D] == r) commit = 1'b0;
    end
    pendPress = 0;
    if (commit) begin
      if (expBstate == 0 && r != 0) begin
        expButton = r;
        expBstate = 1;
        pendPress = 1;
      end else if (expBstate == 1 && r == 0) begin
        expBstate = 0;
      end
    end
  endtask

  // Runs stopAt cycles of a frame, starting just after the edge opening cycle 0.
  task automatic runFrame(input int stopAt);
    logic [2:0] expRows;
    for (int c = 0; c < stopAt; c++) begin
      @(negedge hwclk);
      expRows = 3'b111;
      expRows[c/S] = 1'b0;
      check("rows", rowsOut, expRows);
      check("press", press, (c == 0) ? pendPress : 0);
      check("bstate", bstate, expBstate);
      check("button", button, expButton);
      @(posedge hwclk);
      #1;
    end
    if (stopAt == FRAME) modelFrame();
  endtask

  task automatic runFrames(input int n);
    repeat (n) runFrame(FRAME);
  endtask

  task automatic doReset(input int cyc);
    reset = 1'b1;
    repeat (cyc) @(posedge hwclk);
    #1;
    check("rst_rows", rowsOut, 7);
    check("rst_button", button, 0);
    check("rst_bstate", bstate, 0);
    check("rst_press", press, 0);
    reset = 1'b0;
    hist.delete();
    expButton = 0;
    expBstate = 0;
    pendPress = 0;
  endtask

  initial begin
    int n;
    logic [8:0] k;
    // reset and plain scan order over two frames
    doReset(5);
    runFrames(2);
    // clean press r2c3 then release
    keys = 9'b000_100_000; runFrames(4);
    keys = 9'd0;           runFrames(4);
    // bounce: two good frames, one open frame, then steady
    keys = 9'b000_000_001; runFrames(2);
    keys = 9'd0;           runFrames(1);
    keys = 9'b000_000_001; runFrames(4);
    keys = 9'd0;           runFrames(4);
    // multi-key r1c2 + r3c2, then drop r3c2
    keys = 9'b010_000_010; runFrames(4);
    keys = 9'b000_000_010; runFrames(4);
    keys = 9'd0;           runFrames(4);
    // rolled press r1c1 -> r3c3, release, fresh r3c3
    keys = 9'b000_000_001; runFrames(4);
    keys = 9'b100_000_000; runFrames(5);
    keys = 9'd0;           runFrames(4);
    keys = 9'b100_000_000; runFrames(4);
    keys = 9'd0;           runFrames(4);
    // mid-hold reset with key 5 still held
    keys = 9'b000_010_000; runFrames(4);
    runFrame(5);
    doReset(1);
    runFrames(4);
    keys = 9'd0; runFrames(4);
    // random key patterns with occasional mid-frame resets
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: k = 9'd0;
        1, 2: begin k = 9'd0; k[$urandom_range(0, 8)] = 1'b1; end
        default: begin k = 9'd0; k[$urandom_range(0, 8)] = 1'b1; k[$urandom_range(0, 8)] = 1'b1; end
      endcase
      keys = k;
      n = $urandom_range(1, 5);
      runFrames(n);
      if ($urandom_range(0, 7) == 0) begin
        runFrame($urandom_range(1, FRAME - 1));
        doReset($urandom_range(1, 3));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream key-entry stage. Scans the 3x3 membrane keypad and debounces the scanned result.
- Produces the `button` code and `bstate` level that the top-level controller, key list and sender consume.
- Also produces a one-cycle press strobe, so downstream logic no longer needs its own rising-edge detector on `bstate`.
- Runs entirely on the 12 MHz hardware clock.

Parameters:
- SETTLE_CYCLES, 1200, clock cycles each row is driven before its columns are sampled (100 us at 12 MHz). Must be >= 4.
- DEBOUNCE_FRAMES, 4, consecutive identical full-scan results required before a change is committed. Must be >= 1.

Ports:
- hwclk  input  1  12 MHz clock. Every register is clocked on its rising edge.
- reset  input  1  Synchronous, active-high reset.
- keypad_r1  output  1  Row 1 drive; active-low.
- keypad_r2  output  1  Row 2 drive; active-low.
- keypad_r3  output  1  Row 3 drive; active-low.
- keypad_c1  input  1  Column 1 sense; active-low (pulled up externally); asynchronous.
- keypad_c2  input  1  Column 2 sense; active-low (pulled up externally); asynchronous.
- keypad_c3  input  1  Column 3 sense; active-low (pulled up externally); asynchronous.
- button  output  4  Committed key code. Codes are 1..9; 0 only after reset.
- bstate  output  1  High while a committed key is held.
- press  output  1  One-cycle strobe when a new key is committed.

Behaviour:
- Reset (while reset=1):
  - Rows = 3'b111; button = 0; bstate = 0; press = 0.
  - Dwell counter = 0, row index = r1, frame accumulator = NONE, candidate = NONE, debounce count = 0, FSM = IDLE.
- Column synchronizer:
  - Each column passes through 2 flops before use.
  - Sampling on the last dwell cycle therefore sees row levels that have been stable for at least SETTLE_CYCLES-2 cycles.
- Row scan:
  - The first cycle after reset deasserts drives keypad_r1 low. Exactly one row is low at any time after reset.
  - Each row is held for SETTLE_CYCLES cycles, in the order r1 -> r2 -> r3 -> r1.
  - One frame = 3*SETTLE_CYCLES cycles.
  - On the last dwell cycle of each row, the synchronized columns are sampled into the frame accumulator.
- Frame result:
  - Code = 3*(row-1) + col: r1c1=1, r1c3=3, r2c1=4, r3c3=9.
  - NONE if no column is active in any row.
  - NONE if more than one active column is seen within one row, or active columns are seen in more than one row. Multi-key frames are treated as released.
  - The result is evaluated on the cycle the r3 sample is taken; the accumulator then clears for the next frame.
- Debounce, evaluated once per frame:
  - If result == candidate: count saturates at DEBOUNCE_FRAMES.
  - Otherwise: candidate = result and count = 1.
  - Commit occurs on the frame where count first reaches DEBOUNCE_FRAMES.
  - With DEBOUNCE_FRAMES=1, every frame commits.
- FSM:
  - IDLE, commit code K (1..9): next cycle button = K, bstate = 1, press = 1 for exactly one cycle; go to HELD.
  - IDLE, commit NONE: no change.
  - HELD, commit NONE: next cycle bstate = 0; button keeps its last value; go to IDLE.
  - HELD, commit K' != K (rolled press without a debounced release): ignored; button, bstate and press unchanged.
  - HELD, commit K again: no change; no repeated press.
- Latency: press asserts 1 cycle after the r3 sample of the DEBOUNCE_FRAMES-th matching frame.
- Reset mid-scan or mid-hold: all state returns to reset values on the next edge. Press is never emitted for a key already held at reset until it has debounced afresh.
- Glitch rejection: a bounce that changes any single frame result restarts the count. No output changes unless DEBOUNCE_FRAMES consecutive frames agree.

Test Plan:
All scenarios use SETTLE_CYCLES=4, DEBOUNCE_FRAMES=3 (frame = 12 cycles). The keypad model pulls column c low whenever row r is low and key (r,c) is held.
- Reset behaviour: hold reset 5 cycles -> rows 3'b111, button 0, bstate 0, press 0. First cycle after release: r1 low. r2 low 4 cycles later, r3 4 cycles after that, then back to r1.
- Clean press: hold key r2c3 from cycle 0 -> after 3 full frames, button = 6, bstate = 1, single press pulse. Release -> bstate = 0 after 3 NONE frames, button stays 6, no press.
- Bounce rejection: press r1c1, open it for one sampled frame after 2 good frames, then hold steadily -> no press until 3 consecutive good frames after the bounce, then button = 1 with exactly one press pulse.
- Multi-key: hold r1c2 and r3c2 together -> no press, bstate 0. Release r3c2 -> button = 2 after 3 frames.
- Rolled press: hold r1c1 (committed), then switch directly to r3c3 without a gap -> button stays 1 and bstate stays 1 with no press. Release all, then press r3c3 -> button = 9 with one press.
- Mid-hold reset: with key 5 committed, pulse reset 1 cycle while the key is still held -> bstate = 0 immediately. After 3 frames: bstate = 1, button = 5, one new press pulse.
